imm_ext_pipe: RTL and testbench
===============================

// Module: imm_ext_pipe
// PURPOSE
// - Registered, parametrised immediate extender for the MIPS datapath; successor to the fixed 16->32 sign extender.
// - Adds selectable extension modes and a valid/ready stream interface with a 2-entry skid buffer.
// - Sits between decode and the ALU operand mux, and carries a tag for pipeline bookkeeping.
// PARAMETERS
// - IN_W   16  immediate width; legal range 2..OUT_W-2.
// - OUT_W  32  extended output width.
// - TAG_W  5   sideband tag width (e.g. destination register index).
// PORTS
// - clk           in   1      rising-edge clock; the block has one clock.
// - rst_n         in   1      asynchronous, active-low reset.
// - in_valid      in   1      input beat valid.
// - in_ready      out  1      block can accept a beat.
// - in_imm        in   IN_W   raw immediate.
// - in_mode       in   2      0=SIGN, 1=ZERO, 2=UPPER, 3=BRANCH.
// - in_tag        in   TAG_W  sideband; passed through unchanged.
// - out_valid     out  1      output beat valid.
// - out_ready     in   1      downstream accepts the beat.
// - out_data      out  OUT_W  extended result.
// - out_tag       out  TAG_W  tag aligned with out_data.
// - out_mode_err  out  1      beat used a mode that is compiled out (see CONFIGURATION).
// BEHAVIOUR
// - Reset (asynchronous, rst_n=0): out_valid=0, out_data=0, out_tag=0, out_mode_err=0, skid buffer empty, in_ready=1 one cycle after release.
// - Transfer occurs on valid&&ready at a rising edge; no combinational path from in_* to out_*.
// - Latency: 1 cycle from input acceptance to out_valid while the output is not stalled. Throughput: 1 beat/cycle.
// - in_ready is registered: it is 1 when the skid entry is empty. in_ready does not depend combinationally on out_ready.
// - Stall (out_valid && !out_ready):
//   - out_data, out_tag and out_mode_err hold stable.
//   - A beat accepted in that cycle goes into the skid entry; in_ready drops the next cycle.
// - Drain: when out_ready rises, the skid entry moves to the output register and in_ready returns to 1 the following cycle.
// - Beats are never dropped or reordered.
// - Simultaneous accept and drain with the skid entry empty: the output register reloads directly; skid stays empty.
// - Arithmetic, with E = OUT_W-IN_W:
//   - SIGN:   {{E{imm[IN_W-1]}}, imm}
//   - ZERO:   {{E{1'b0}}, imm}
//   - UPPER:  {imm, {E{1'b0}}}, truncated to OUT_W
//   - BRANCH: sign-extend, then << 2; the top 2 bits are discarded (wrap, no saturation).
// - Reset mid-operation discards the output register and skid content immediately; nothing is replayed after release.
// - X on in_imm while in_valid=0 must not propagate to out_data.
// CONFIGURATION
// - Macro IMM_EXT_BRANCH_EN.
// - Defined: mode 3 = BRANCH as above; out_mode_err is tied to 0.
// - Undefined: mode 3 produces the SIGN result and out_mode_err=1 for that beat; the shift logic is absent.
// STRUCTURE
// - Package mips_ext_pkg:
//   - localparams EXT_SIGN=2'd0, EXT_ZERO=2'd1, EXT_UPPER=2'd2, EXT_BRANCH=2'd3;
//   - typedef ext_mode_t (2-bit);
//   - function ext_calc(imm, mode) shared with the reference model.
// - Sub-module ext_skid_buf:
//   - generic 1-entry skid plus output register with valid/ready;
//   - payload width = OUT_W+TAG_W+1.
// - The top level holds the extension mux feeding the skid buffer.
// TESTING
// - SIGN, in_imm=16'ha43d, out_ready=1 -> next cycle out_data=32'hffffa43d, out_valid=1.
// - ZERO 16'ha43d -> 32'h0000a43d. UPPER 16'h7a0b -> 32'h7a0b0000, tag 5'd9 echoed.
// - BRANCH 16'hfffe -> 32'hfffffff8 with out_mode_err=0; with the macro undefined -> 32'hfffffffe and out_mode_err=1.
// - Backpressure:
//   - hold out_ready=0 and offer 3 beats -> only 2 accepted, in_ready=0 from the cycle after the 2nd;
//   - release -> beats emerge in order, values held stable during the stall.
// - Reset mid-stream: assert rst_n=0 between edges with 2 beats held -> out_valid=0 immediately; after release in_ready=1 and no stale beat appears.
// - Random stream, 10k beats, random valid/ready toggling -> scoreboard against ext_calc: zero mismatches, no loss.

Source files
------------

// File: rtl/mips_ext_pkg.sv
// Shared types, mode encodings and the extension function for imm_ext_pipe.
// Optional feature macro: IMM_EXT_BRANCH_EN (enables the BRANCH <<2 mode).
package mips_ext_pkg;

    localparam int unsigned EXT_MAX_W = 64;

    typedef logic [1:0] ext_mode_t;

    localparam ext_mode_t EXT_SIGN   = 2'd0;
    localparam ext_mode_t EXT_ZERO   = 2'd1;
    localparam ext_mode_t EXT_UPPER  = 2'd2;
    localparam ext_mode_t EXT_BRANCH = 2'd3;

    // Width-generic extension; in_w/out_w are constants at every call site.
    function automatic logic [EXT_MAX_W-1:0] ext_calc(
        input logic [EXT_MAX_W-1:0] imm,
        input ext_mode_t            mode,
        input int unsigned          in_w,
        input int unsigned          out_w
    );
        logic [EXT_MAX_W-1:0] in_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] zx;
        logic [EXT_MAX_W-1:0] sx;
        logic [EXT_MAX_W-1:0] res;
        in_mask  = (EXT_MAX_W'(1) << in_w) - EXT_MAX_W'(1);
        out_mask = (out_w >= EXT_MAX_W) ? {EXT_MAX_W{1'b1}}
                                        : ((EXT_MAX_W'(1) << out_w) - EXT_MAX_W'(1));
        zx = imm & in_mask;
        sx = ((imm & (EXT_MAX_W'(1) << (in_w - 1))) != '0) ? (zx | ~in_mask) : zx;
        case (mode)
            EXT_SIGN:   res = sx;
            EXT_ZERO:   res = zx;
            EXT_UPPER:  res = zx << (out_w - in_w);
`ifdef IMM_EXT_BRANCH_EN
            EXT_BRANCH: res = sx << 2;
`endif
            default:    res = sx;
        endcase
        return res & out_mask;
    endfunction

endpackage

// File: rtl/ext_skid_buf.sv
// Generic valid/ready stage: one output register plus one skid entry.
// in_ready is registered and never depends combinationally on out_ready.
module ext_skid_buf #(
    parameter int unsigned WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             in_ready_q,   in_ready_d;
    logic             accept_c;

    // Next-state: drain skid first, else load output directly, else park in skid.
    always_comb begin
        accept_c     = in_valid && in_ready_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (skid_valid_q) begin
            if (out_ready) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (!out_valid_q || out_ready) begin
            out_valid_d = accept_c;
            if (accept_c) begin
                out_data_d = in_data;
            end
        end else if (accept_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset empties both entries immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            in_ready_q   <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with valid/ready stream and tag sideband.
// Macro IMM_EXT_BRANCH_EN: when undefined, mode 3 yields SIGN and flags out_mode_err.
module imm_ext_pipe
    import mips_ext_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_mode_err
);

    localparam int unsigned PAY_W = OUT_W + TAG_W + 1;

    logic [OUT_W-1:0] ext_data_c;
    logic             mode_err_c;
    logic [PAY_W-1:0] in_pay_c;
    logic [PAY_W-1:0] out_pay;

    // Extension mux; only captured on an accepted beat.
    assign ext_data_c = OUT_W'(ext_calc(EXT_MAX_W'(in_imm), ext_mode_t'(in_mode), IN_W, OUT_W));

`ifdef IMM_EXT_BRANCH_EN
    assign mode_err_c = 1'b0;
`else
    assign mode_err_c = (ext_mode_t'(in_mode) == EXT_BRANCH);
`endif

    assign in_pay_c = {mode_err_c, in_tag, ext_data_c};

    ext_skid_buf #(
        .WIDTH(PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {out_mode_err, out_tag, out_data} = out_pay;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed and random stream bench for imm_ext_pipe with a queue scoreboard.
module tb_imm_ext_pipe;
    import mips_ext_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm;
    logic [1:0]  in_mode;
    logic [4:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_mode_err;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic        stall_prev = 1'b0;
    logic [38:0] held_prev  = '0;

    imm_ext_pipe dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_imm       (in_imm),
        .in_mode      (in_mode),
        .in_tag       (in_tag),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_tag      (out_tag),
        .out_mode_err (out_mode_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [31:0] d, input logic [4:0] t, input logic e);
        exp_t r;
        r.data = d;
        r.tag  = t;
        r.err  = e;
        return r;
    endfunction

    // Independent reference for the default 16->32 configuration.
    function automatic exp_t model(input logic [15:0] imm, input logic [1:0] mode, input logic [4:0] tag);
        logic [31:0] sx;
        sx = {{16{imm[15]}}, imm};
        case (mode)
            2'd0:    return mk(sx, tag, 1'b0);
            2'd1:    return mk({16'h0000, imm}, tag, 1'b0);
            2'd2:    return mk({imm, 16'h0000}, tag, 1'b0);
`ifdef IMM_EXT_BRANCH_EN
            default: return mk({sx[29:0], 2'b00}, tag, 1'b0);
`else
            default: return mk(sx, tag, 1'b1);
`endif
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // One clock: drive at negedge, score outputs, push accepted beats.
    task automatic cycle(input logic v, input logic [15:0] imm, input logic [1:0] mode,
                         input logic [4:0] tag, input logic ordy, input exp_t e,
                         input int exp_ov, output logic acc);
        exp_t x;
        @(negedge clk);
        in_valid  = v;
        in_imm    = v ? imm  : 16'bx;
        in_mode   = v ? mode : 2'bx;
        in_tag    = v ? tag  : 5'bx;
        out_ready = ordy;
        #1;
        if (exp_ov >= 0) check("out_valid", 64'(out_valid), 64'(exp_ov));
        if (stall_prev) check("stall_hold", 64'({out_valid, out_mode_err, out_tag, out_data}), 64'(held_prev));
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_beat", 64'(out_valid), 64'(0));
            end else begin
                x = sb.pop_front();
                check("out_data", 64'(out_data), 64'(x.data));
                check("out_tag", 64'(out_tag), 64'(x.tag));
                check("out_mode_err", 64'(out_mode_err), 64'(x.err));
            end
        end
        stall_prev = out_valid && !out_ready;
        held_prev  = {out_valid, out_mode_err, out_tag, out_data};
        acc = v && in_ready;
        if (acc) sb.push_back(e);
    endtask

    initial begin
        exp_t       none;
        exp_t       dir_e[9];
        logic [15:0] dir_imm[9];
        logic [1:0]  dir_mode[9];
        logic [4:0]  dir_tag[9];
        logic       acc;
        int         n;
        int         budget;

        none = '0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_imm = 'x; in_mode = 'x; in_tag = 'x;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_tag", 64'(out_tag), 64'(0));
        check("rst_out_mode_err", 64'(out_mode_err), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 64'(in_ready), 64'(1));

        // Directed patterns, back-to-back with out_ready=1
        dir_imm[0] = 16'ha43d; dir_mode[0] = EXT_SIGN;   dir_tag[0] = 5'd1;  dir_e[0] = mk(32'hffffa43d, 5'd1, 1'b0);
        dir_imm[1] = 16'ha43d; dir_mode[1] = EXT_ZERO;   dir_tag[1] = 5'd2;  dir_e[1] = mk(32'h0000a43d, 5'd2, 1'b0);
        dir_imm[2] = 16'h7a0b; dir_mode[2] = EXT_UPPER;  dir_tag[2] = 5'd9;  dir_e[2] = mk(32'h7a0b0000, 5'd9, 1'b0);
`ifdef IMM_EXT_BRANCH_EN
        dir_imm[3] = 16'hfffe; dir_mode[3] = EXT_BRANCH; dir_tag[3] = 5'd3;  dir_e[3] = mk(32'hfffffff8, 5'd3, 1'b0);
        dir_imm[6] = 16'h8000; dir_mode[6] = EXT_BRANCH; dir_tag[6] = 5'd6;  dir_e[6] = mk(32'hfffe0000, 5'd6, 1'b0);
        dir_imm[8] = 16'h0001; dir_mode[8] = EXT_BRANCH; dir_tag[8] = 5'd7;  dir_e[8] = mk(32'h00000004, 5'd7, 1'b0);
`else
        dir_imm[3] = 16'hfffe; dir_mode[3] = EXT_BRANCH; dir_tag[3] = 5'd3;  dir_e[3] = mk(32'hfffffffe, 5'd3, 1'b1);
        dir_imm[6] = 16'h8000; dir_mode[6] = EXT_BRANCH; dir_tag[6] = 5'd6;  dir_e[6] = mk(32'hffff8000, 5'd6, 1'b1);
        dir_imm[8] = 16'h0001; dir_mode[8] = EXT_BRANCH; dir_tag[8] = 5'd7;  dir_e[8] = mk(32'h00000001, 5'd7, 1'b1);
`endif
        dir_imm[4] = 16'h7fff; dir_mode[4] = EXT_SIGN;   dir_tag[4] = 5'd4;  dir_e[4] = mk(32'h00007fff, 5'd4, 1'b0);
        dir_imm[5] = 16'hffff; dir_mode[5] = EXT_ZERO;   dir_tag[5] = 5'd5;  dir_e[5] = mk(32'h0000ffff, 5'd5, 1'b0);
        dir_imm[7] = 16'hffff; dir_mode[7] = EXT_UPPER;  dir_tag[7] = 5'd31; dir_e[7] = mk(32'hffff0000, 5'd31, 1'b0);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b1, dir_imm[i], dir_mode[i], dir_tag[i], 1'b1, dir_e[i], (i == 0) ? 0 : 1, acc);
            check("dir_accept", 64'(acc), 64'(1));
        end
        cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, 1, acc);
        cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, 0, acc);

        // Backpressure: only two beats fit while stalled
        cycle(1'b1, 16'h1111, EXT_SIGN, 5'd10, 1'b0, mk(32'h00001111, 5'd10, 1'b0), 0, acc);
        check("bp_accept_1", 64'(acc), 64'(1));
        cycle(1'b1, 16'h8222, EXT_ZERO, 5'd11, 1'b0, mk(32'h00008222, 5'd11, 1'b0), 1, acc);
        check("bp_accept_2", 64'(acc), 64'(1));
        cycle(1'b1, 16'h8333, EXT_SIGN, 5'd12, 1'b0, mk(32'hffff8333, 5'd12, 1'b0), 1, acc);
        check("bp_third_blocked", 64'(acc), 64'(0));
        check("bp_in_ready_low", 64'(in_ready), 64'(0));
        check("bp_held_data", 64'(out_data), 64'(32'h00001111));
        cycle(1'b1, 16'h8333, EXT_SIGN, 5'd12, 1'b0, mk(32'hffff8333, 5'd12, 1'b0), 1, acc);
        check("bp_still_blocked", 64'(acc), 64'(0));
        cycle(1'b1, 16'h8333, EXT_SIGN, 5'd12, 1'b1, mk(32'hffff8333, 5'd12, 1'b0), 1, acc);
        check("bp_drain_blocked", 64'(acc), 64'(0));
        cycle(1'b1, 16'h8333, EXT_SIGN, 5'd12, 1'b1, mk(32'hffff8333, 5'd12, 1'b0), 1, acc);
        check("ready_after_drain", 64'(acc), 64'(1));
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, -1, acc);
            budget++;
        end
        check("bp_no_loss", 64'(sb.size()), 64'(0));

        // Reset mid-stream with two beats held
        cycle(1'b1, 16'h1234, EXT_ZERO, 5'd13, 1'b0, mk(32'h00001234, 5'd13, 1'b0), -1, acc);
        cycle(1'b1, 16'h5678, EXT_ZERO, 5'd14, 1'b0, mk(32'h00005678, 5'd14, 1'b0), 1, acc);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        sb.delete();
        stall_prev = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 64'(in_ready), 64'(1));
        for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, 0, acc);

        // Random stream with random valid/ready
        n = 0;
        budget = 0;
        while (n < 10000 && budget < 60000) begin
            logic [15:0] r_imm;
            logic [1:0]  r_mode;
            logic [4:0]  r_tag;
            logic        r_v;
            logic        r_rdy;
            r_imm  = 16'($urandom);
            r_mode = 2'($urandom_range(0, 3));
            r_tag  = 5'($urandom);
            r_v    = ($urandom_range(0, 9) < 7);
            r_rdy  = ($urandom_range(0, 9) < 7);
            cycle(r_v, r_imm, r_mode, r_tag, r_rdy, model(r_imm, r_mode, r_tag), -1, acc);
            if (acc) n++;
            budget++;
        end
        check("rand_beats_accepted", 64'(n), 64'(10000));
        budget = 0;
        while (sb.size() != 0 && budget < 10) begin
            cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, -1, acc);
            budget++;
        end
        check("rand_no_loss", 64'(sb.size()), 64'(0));
        cycle(1'b0, 16'h0, 2'd0, 5'd0, 1'b1, none, 0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
